// File: rtl/traffic_light_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pkg
//  Brief    : State encoding, lamp encodings and duration lookup shared by
//             the traffic light sequencer and its timer interface stage.
//  Revision : 1.0
// ============================================================================
package tl_pkg;

    typedef enum logic [3:0] {
        MAIN_GREEN  = 4'd0,
        MAIN_YELLOW = 4'd1,
        ALL_RED_M   = 4'd2,
        SIDE_GREEN  = 4'd3,
        SIDE_YELLOW = 4'd4,
        ALL_RED_S   = 4'd5,
        PED_WALK    = 4'd6,
        FLASH_ON    = 4'd7,
        FLASH_OFF   = 4'd8
    } tlState_e;

    // Lamp order is {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    function automatic int unsigned stateDuration(
        input tlState_e    s,
        input int unsigned tMainGreen,
        input int unsigned tSideGreen,
        input int unsigned tYellow,
        input int unsigned tAllRed,
        input int unsigned tWalk,
        input int unsigned tFlash
    );
        case (s)
            MAIN_GREEN:              return tMainGreen;
            SIDE_GREEN:              return tSideGreen;
            MAIN_YELLOW, SIDE_YELLOW: return tYellow;
            PED_WALK:                return tWalk;
            FLASH_ON, FLASH_OFF:     return tFlash;
            default:                 return tAllRed;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_sequencer_if
//  Brief    : Handshake bundle between the sequencer and the seconds timer.
//  Revision : 1.0
// ============================================================================
interface traffic_light_sequencer_if #(
    parameter int TW = 7
);
    logic          start_counting;
    logic [TW-1:0] seconds_to_count;
    logic          time_finished;

    modport master (
        output start_counting,
        output seconds_to_count,
        input  time_finished
    );

    modport slave (
        input  start_counting,
        input  seconds_to_count,
        output time_finished
    );
endinterface
`default_nettype wire

// File: rtl/traffic_light_sequencer_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tl_timer_if
//  Brief    : Start-pulse generator, interval register and arming counter
//             that shields the FSM from a stale time_finished after restart.
//  Revision : 1.0
// ============================================================================
module tl_timer_if #(
    parameter int          TW            = 7,
    parameter int unsigned RESET_SECONDS = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          stateEntry,
    input  wire logic [TW-1:0] entrySeconds,
    output logic               armed,
    traffic_light_sequencer_if.master timerBus
);

    logic          r_start;
    logic [TW-1:0] r_seconds;
    logic [1:0]    r_armCnt;
    logic          r_armed;

    // armed rises two cycles after the start pulse, when the timer output is fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start   <= 1'b0;
            r_seconds <= TW'(RESET_SECONDS);
            r_armCnt  <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_start <= stateEntry;
            if (stateEntry) begin
                r_seconds <= entrySeconds;
                r_armCnt  <= 2'd0;
                r_armed   <= 1'b0;
            end else begin
                if (r_armCnt != 2'd2) begin
                    r_armCnt <= r_armCnt + 2'd1;
                end
                if (r_armCnt == 2'd1) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    assign timerBus.start_counting   = r_start;
    assign timerBus.seconds_to_count = r_seconds;
    assign armed                     = r_armed;

endmodule
`default_nettype wire

// File: rtl/traffic_light_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_sequencer
//  Brief    : Two-road intersection controller with pedestrian phase and
//             flashing-yellow standby, driving an external seconds timer.
//  Revision : 1.0
// ============================================================================
module traffic_light_sequencer
    import tl_pkg::*;
#(
    parameter int unsigned T_MAIN_GREEN = 30,
    parameter int unsigned T_SIDE_GREEN = 20,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 1,
    parameter int unsigned T_WALK       = 10,
    parameter int unsigned T_FLASH      = 1,
    parameter int          TW           = 7
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic enable,
    input  wire logic ped_req,
    traffic_light_sequencer_if.master timerBus,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_pending
);

    localparam int unsigned c_LIMIT = 32'd1 << TW;

    if (T_MAIN_GREEN < 1 || T_MAIN_GREEN >= c_LIMIT ||
        T_SIDE_GREEN < 1 || T_SIDE_GREEN >= c_LIMIT ||
        T_YELLOW     < 1 || T_YELLOW     >= c_LIMIT ||
        T_ALL_RED    < 1 || T_ALL_RED    >= c_LIMIT ||
        T_WALK       < 1 || T_WALK       >= c_LIMIT ||
        T_FLASH      < 1 || T_FLASH      >= c_LIMIT) begin : g_durationCheck
        $error("traffic_light_sequencer: every T_* must be >= 1 and fit in TW bits");
    end

    tlState_e      r_state;
    tlState_e      w_nextState;
    logic          r_entryPending;
    logic          r_pedPending;
    logic          w_armed;
    logic          w_done;
    logic          w_isFlash;
    logic          w_stateEntry;
    logic [2:0]    w_mainLight;
    logic [2:0]    w_sideLight;
    logic          w_walk;
    logic [TW-1:0] w_entrySeconds;

    // r_entryPending forces a start pulse on the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ALL_RED_M;
            r_entryPending <= 1'b1;
            r_pedPending   <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_entryPending <= 1'b0;
            if (w_stateEntry && (w_nextState == PED_WALK)) begin
                r_pedPending <= 1'b0;
            end else if (ped_req) begin
                r_pedPending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_mainLight = RED;
        w_sideLight = RED;
        w_walk      = 1'b0;
        w_done      = w_armed && timerBus.time_finished;
        w_isFlash   = (r_state == FLASH_ON) || (r_state == FLASH_OFF);

        case (r_state)
            MAIN_GREEN: begin
                w_mainLight = GRN;
                if (w_done) w_nextState = MAIN_YELLOW;
            end
            MAIN_YELLOW: begin
                w_mainLight = YEL;
                if (w_done) w_nextState = ALL_RED_M;
            end
            ALL_RED_M: begin
                // a request arriving in the completing cycle still wins the walk phase
                if (w_done) w_nextState = (r_pedPending || ped_req) ? PED_WALK : SIDE_GREEN;
            end
            SIDE_GREEN: begin
                w_sideLight = GRN;
                if (w_done) w_nextState = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                w_sideLight = YEL;
                if (w_done) w_nextState = ALL_RED_S;
            end
            ALL_RED_S: begin
                if (w_done) w_nextState = MAIN_GREEN;
            end
            PED_WALK: begin
                w_walk = 1'b1;
                if (w_done) w_nextState = SIDE_GREEN;
            end
            FLASH_ON: begin
                w_mainLight = YEL;
                w_sideLight = YEL;
                if (w_done) w_nextState = FLASH_OFF;
            end
            FLASH_OFF: begin
                w_mainLight = OFF;
                w_sideLight = OFF;
                if (w_done) w_nextState = FLASH_ON;
            end
            default: w_nextState = ALL_RED_M;
        endcase

        // The enable input overrides any timer-driven move
        if (w_isFlash) begin
            if (enable) w_nextState = ALL_RED_M;
        end else if (!enable) begin
            w_nextState = FLASH_ON;
        end

        w_stateEntry   = r_entryPending || (w_nextState != r_state);
        w_entrySeconds = TW'(stateDuration(w_nextState, T_MAIN_GREEN, T_SIDE_GREEN,
                                           T_YELLOW, T_ALL_RED, T_WALK, T_FLASH));
    end

    tl_timer_if #(
        .TW            (TW),
        .RESET_SECONDS (T_ALL_RED)
    ) u_timerIf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stateEntry   (w_stateEntry),
        .entrySeconds (w_entrySeconds),
        .armed        (w_armed),
        .timerBus     (timerBus)
    );

    assign main_light  = w_mainLight;
    assign side_light  = w_sideLight;
    assign walk        = w_walk;
    assign ped_pending = r_pedPending;

endmodule
`default_nettype wire
